// File: rtl/latency_meter_pkg.sv
// Shared types and helpers for the loopback latency meter.
// Holds the FSM state encoding, statistics reset constants and a saturating increment.
package latency_meter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    // Widest counter the saturating helper supports.
    localparam int SAT_MAX_W = 32;

    localparam logic [SAT_MAX_W-1:0] STAT_ZERO = '0;
    localparam logic [SAT_MAX_W-1:0] STAT_ONES = '1;

    // Increment v unless it already holds the all-ones value of a w-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int unsigned w);
        logic [63:0] ones;
        ones = (64'd1 << w) - 64'd1;
        return ({32'd0, v} >= ones) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/latency_meter_if.sv
// Strobe inputs and measurement/statistics outputs of the latency meter.
// master drives the strobes, slave is the meter itself.
interface latency_meter_if #(
    parameter int CNT_W = 16,
    parameter int SUM_W = 32,
    parameter int SMP_W = 16
) ();
    logic             i_start;
    logic             i_stop;
    logic             i_clear;
    logic             o_busy;
    logic             o_valid;
    logic [CNT_W-1:0] o_latency;
    logic             o_timeout;
    logic [CNT_W-1:0] o_min;
    logic [CNT_W-1:0] o_max;
    logic [SUM_W-1:0] o_sum;
    logic [SMP_W-1:0] o_samples;
    logic [SMP_W-1:0] o_timeouts;
    logic [SMP_W-1:0] o_restarts;

    modport master (
        output i_start, i_stop, i_clear,
        input  o_busy, o_valid, o_latency, o_timeout, o_min, o_max, o_sum,
               o_samples, o_timeouts, o_restarts
    );

    modport slave (
        input  i_start, i_stop, i_clear,
        output o_busy, o_valid, o_latency, o_timeout, o_min, o_max, o_sum,
               o_samples, o_timeouts, o_restarts
    );
endinterface

// File: rtl/latency_stats.sv
// Min/max/sum/sample accumulators for completed latency measurements.
// Latency: results visible the cycle after i_update or i_clear.
// Backpressure: none; every update strobe is absorbed, clear overrides update.
module latency_stats
    import latency_meter_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SUM_W = 32,
    parameter int SMP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_update,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_latency,
    output logic [CNT_W-1:0] o_min,
    output logic [CNT_W-1:0] o_max,
    output logic [SUM_W-1:0] o_sum,
    output logic [SMP_W-1:0] o_samples
);
    localparam int ADD_W = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;
    localparam logic [CNT_W-1:0] MIN_INIT  = STAT_ONES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] MAX_INIT  = STAT_ZERO[CNT_W-1:0];
    localparam logic [SUM_W-1:0] SUM_INIT  = STAT_ZERO[SUM_W-1:0];
    localparam logic [SUM_W-1:0] SUM_ONES  = STAT_ONES[SUM_W-1:0];
    localparam logic [SMP_W-1:0] SMP_INIT  = STAT_ZERO[SMP_W-1:0];
    localparam logic [SMP_W-1:0] SMP_ONES  = STAT_ONES[SMP_W-1:0];

    logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SMP_W-1:0] samples_q, samples_d;
    logic [ADD_W-1:0] sum_ext;

    always_comb begin
        min_d     = min_q;
        max_d     = max_q;
        sum_d     = sum_q;
        samples_d = samples_q;
        sum_ext   = ADD_W'(sum_q) + ADD_W'(i_latency);
        if (i_clear) begin
            min_d     = MIN_INIT;
            max_d     = MAX_INIT;
            sum_d     = SUM_INIT;
            samples_d = SMP_INIT;
        end else if (i_update && (samples_q != SMP_ONES)) begin
            // A saturated sample count freezes min/max/sum so sum/samples stays meaningful.
            min_d     = (i_latency < min_q) ? i_latency : min_q;
            max_d     = (i_latency > max_q) ? i_latency : max_q;
            sum_d     = (sum_ext > ADD_W'(SUM_ONES)) ? SUM_ONES : sum_ext[SUM_W-1:0];
            samples_d = SMP_W'(sat_inc(SAT_MAX_W'(samples_q), SMP_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q     <= MIN_INIT;
            max_q     <= MAX_INIT;
            sum_q     <= SUM_INIT;
            samples_q <= SMP_INIT;
        end else begin
            min_q     <= min_d;
            max_q     <= max_d;
            sum_q     <= sum_d;
            samples_q <= samples_d;
        end
    end

    assign o_min     = min_q;
    assign o_max     = max_q;
    assign o_sum     = sum_q;
    assign o_samples = samples_q;
endmodule

// File: rtl/latency_meter.sv
// Loopback latency meter: counts cycles from start strobe to stop strobe, keeps statistics.
// Latency: o_valid/o_timeout and statistics appear 1 cycle after the stop/timeout cycle.
// Backpressure: none; strobes are single-cycle and always accepted.
module latency_meter
    import latency_meter_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000,
    parameter int SUM_W   = 32,
    parameter int SMP_W   = 16
) (
    input  logic           i_tx_clk,
    input  logic           i_rst_n,
    latency_meter_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [SMP_W-1:0] timeouts_q, timeouts_d;
    logic [SMP_W-1:0] restarts_q, restarts_d;
    logic             sample, restart, expire;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latency_d = latency_q;
        sample    = 1'b0;
        restart   = 1'b0;
        expire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                // Stop wins over start; a simultaneous start opens the next measurement.
                if (bus.i_stop) begin
                    sample    = 1'b1;
                    latency_d = cnt_q;
                    if (bus.i_start) begin
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else if (bus.i_start) begin
                    restart = 1'b1;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    expire  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        valid_d    = sample;
        timeout_d  = expire;
        timeouts_d = timeouts_q;
        restarts_d = restarts_q;
        if (bus.i_clear) begin
            timeouts_d = '0;
            restarts_d = '0;
        end else begin
            if (expire)  timeouts_d = SMP_W'(sat_inc(SAT_MAX_W'(timeouts_q), SMP_W));
            if (restart) restarts_d = SMP_W'(sat_inc(SAT_MAX_W'(restarts_q), SMP_W));
        end
    end

    always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            latency_q  <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            timeouts_q <= '0;
            restarts_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            latency_q  <= latency_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            timeouts_q <= timeouts_d;
            restarts_q <= restarts_d;
        end
    end

    latency_stats #(
        .CNT_W (CNT_W),
        .SUM_W (SUM_W),
        .SMP_W (SMP_W)
    ) u_stats (
        .clk       (i_tx_clk),
        .rst_n     (i_rst_n),
        .i_update  (sample),
        .i_clear   (bus.i_clear),
        .i_latency (cnt_q),
        .o_min     (bus.o_min),
        .o_max     (bus.o_max),
        .o_sum     (bus.o_sum),
        .o_samples (bus.o_samples)
    );

    assign bus.o_busy     = (state_q == ST_MEASURE);
    assign bus.o_valid    = valid_q;
    assign bus.o_latency  = latency_q;
    assign bus.o_timeout  = timeout_q;
    assign bus.o_timeouts = timeouts_q;
    assign bus.o_restarts = restarts_q;
endmodule

// File: tb/tb_latency_meter.sv
// Bench for latency_meter: directed scenarios then random strobes, checked every cycle
// against a timestamp-based model of open measurements and running statistics.
module tb_latency_meter;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 8;
    localparam int SUM_W   = 6;
    localparam int SMP_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int SUM_MAX = (1 << SUM_W) - 1;
    localparam int SMP_MAX = (1 << SMP_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    latency_meter_if #(.CNT_W(CNT_W), .SUM_W(SUM_W), .SMP_W(SMP_W)) bus ();

    latency_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SUM_W(SUM_W), .SMP_W(SMP_W)) dut (
        .i_tx_clk (clk),
        .i_rst_n  (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Model: an open measurement is just the cycle number of its start.
    int cyc;
    bit m_busy;
    int m_start;
    int e_valid, e_latency, e_timeout, e_min, e_max, e_sum, e_samples, e_timeouts, e_restarts;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_start = 0;
        e_valid = 0; e_latency = 0; e_timeout = 0;
        e_min = CNT_MAX; e_max = 0; e_sum = 0; e_samples = 0; e_timeouts = 0; e_restarts = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit c);
        bit sample, expire, restart;
        int el;
        sample = 0; expire = 0; restart = 0;
        if (!m_busy) begin
            if (s) begin m_busy = 1; m_start = cyc; end
        end else begin
            el = cyc - m_start;
            if (p) begin
                sample = 1; e_latency = el;
                if (s) m_start = cyc; else m_busy = 0;
            end else if (s) begin
                restart = 1; m_start = cyc;
            end else if (el == TIMEOUT) begin
                expire = 1; m_busy = 0;
            end
        end
        e_valid = sample;
        e_timeout = expire;
        if (c) begin
            e_min = CNT_MAX; e_max = 0; e_sum = 0; e_samples = 0; e_timeouts = 0; e_restarts = 0;
        end else begin
            if (sample && e_samples < SMP_MAX) begin
                if (e_latency < e_min) e_min = e_latency;
                if (e_latency > e_max) e_max = e_latency;
                e_sum = (e_sum + e_latency > SUM_MAX) ? SUM_MAX : e_sum + e_latency;
                e_samples++;
            end
            if (expire && e_timeouts < SMP_MAX) e_timeouts++;
            if (restart && e_restarts < SMP_MAX) e_restarts++;
        end
    endtask

    task automatic check_all();
        chk("busy",     32'(bus.o_busy),     32'(m_busy));
        chk("valid",    32'(bus.o_valid),    e_valid);
        chk("latency",  32'(bus.o_latency),  e_latency);
        chk("timeout",  32'(bus.o_timeout),  e_timeout);
        chk("min",      32'(bus.o_min),      e_min);
        chk("max",      32'(bus.o_max),      e_max);
        chk("sum",      32'(bus.o_sum),      e_sum);
        chk("samples",  32'(bus.o_samples),  e_samples);
        chk("timeouts", 32'(bus.o_timeouts), e_timeouts);
        chk("restarts", 32'(bus.o_restarts), e_restarts);
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic cycle(input bit s, input bit p, input bit c);
        bus.i_start = s; bus.i_stop = p; bus.i_clear = c;
        @(posedge clk);
        cyc++;
        model_step(s, p, c);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    task automatic meas(input int n);
        cycle(1, 0, 0);
        idle(n - 1);
        cycle(0, 1, 0);
    endtask

    initial begin
        bus.i_start = 0; bus.i_stop = 0; bus.i_clear = 0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Single 5-cycle measurement.
        meas(5);
        chk("t1_latency", 32'(bus.o_latency), 5);
        chk("t1_samples", 32'(bus.o_samples), 1);
        cycle(0, 0, 1);

        // Several measurements, including a stop exactly at TIMEOUT.
        meas(3); meas(TIMEOUT); meas(6);
        chk("t2_min", 32'(bus.o_min), 3);
        chk("t2_max", 32'(bus.o_max), TIMEOUT);
        chk("t2_sum", 32'(bus.o_sum), 3 + TIMEOUT + 6);

        // Unanswered start times out.
        cycle(1, 0, 0);
        idle(TIMEOUT);
        chk("t3_timeout", 32'(bus.o_timeout), 1);
        idle(2);

        // Restart then stop.
        cycle(1, 0, 0); idle(3); cycle(1, 0, 0); idle(1); cycle(0, 1, 0);
        chk("t4_latency", 32'(bus.o_latency), 2);

        // Start+stop together while busy.
        cycle(1, 0, 0); idle(6); cycle(1, 1, 0);
        chk("t5_busy", 32'(bus.o_busy), 1);
        idle(2); cycle(0, 1, 0);
        chk("t5_latency", 32'(bus.o_latency), 3);

        // Asynchronous reset mid-measurement, then a stray stop.
        cycle(1, 0, 0); idle(2);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        rst_n = 1'b1;
        cycle(0, 1, 0);

        // Clear coinciding with a completing stop.
        cycle(1, 0, 0); idle(2); cycle(0, 1, 1);
        chk("t6_valid", 32'(bus.o_valid), 1);
        idle(1);

        // Saturate sum and sample count, then restart count.
        for (int i = 0; i < SMP_MAX + 3; i++) meas(TIMEOUT - (i % 3));
        for (int i = 0; i < SMP_MAX + 3; i++) cycle(1, 0, 0);
        idle(TIMEOUT + 1);
        cycle(0, 0, 1);

        // Random strobes.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 59) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
